// File: rtl/img_highlight_ctrl.sv
// Frame-synchronous highlight controller for the VGA image overlay.
// Key events are captured at any time; highlights change only once per frame at the update position.
module img_highlight_ctrl #(
   parameter int HOLD_FRAMES = 8,
   parameter int CNT_W       = 4,
   parameter int UPDATE_LINE = 480
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       key_release,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   output logic       aI,
   output logic       bI,
   output logic       cI,
   output logic       dI,
   output logic       upI,
   output logic       downI,
   output logic       leftI,
   output logic       rightI,
   output logic       frame_tick
);

   typedef enum logic [2:0] {
      OWN_NONE  = 3'd0,
      OWN_UP    = 3'd1,
      OWN_DOWN  = 3'd2,
      OWN_LEFT  = 3'd3,
      OWN_RIGHT = 3'd4
   } owner_e;

   localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_FRAMES);

   logic                  upd, tick;
   logic                  upd_q;
   logic                  frame_tick_q, frame_tick_d;
   logic [7:0]            pressed_q, pressed_d;
   logic [3:0]            pending_q, pending_d;
   logic [3:0]            lout_q, lout_d;
   logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0]      acnt_q, acnt_d;
   owner_e                owner_q, owner_d;
   owner_e                apend_q, apend_d;
   logic [3:0]            own_code;

   assign upd      = (pixel_y == 10'(UPDATE_LINE)) && (pixel_x == 10'd0);
   assign tick     = upd & ~upd_q;
   // Owner encoding is offset by 3 from the arrow key codes (UP=1 <-> code 4).
   assign own_code = 4'(owner_q) + 4'd3;

   always_comb begin
      pressed_d    = pressed_q;
      pending_d    = pending_q;
      lout_d       = lout_q;
      cnt_d        = cnt_q;
      acnt_d       = acnt_q;
      owner_d      = owner_q;
      apend_d      = apend_q;
      frame_tick_d = tick;

      if (tick) begin
         pending_d = '0;
         apend_d   = OWN_NONE;
         for (int k = 0; k < 4; k++) begin
            if (pressed_q[k] | pending_q[k]) begin
               cnt_d[k]  = HOLD;
               lout_d[k] = 1'b1;
            end else if (cnt_q[k] != '0) begin
               cnt_d[k]  = cnt_q[k] - 1'b1;
               lout_d[k] = (cnt_q[k] != CNT_W'(1));
            end else begin
               lout_d[k] = 1'b0;
            end
         end
         if (apend_q != OWN_NONE) begin
            owner_d = apend_q;
            acnt_d  = HOLD;
         end else if (owner_q != OWN_NONE && pressed_q[own_code[2:0]]) begin
            acnt_d = HOLD;
         end else if (acnt_q != '0) begin
            acnt_d = acnt_q - 1'b1;
            if (acnt_q == CNT_W'(1)) owner_d = OWN_NONE;
         end
      end

      // Applied after the tick clear so a same-cycle event lands in the next frame.
      if (key_valid && !key_code[3]) begin
         if (key_release) begin
            pressed_d[key_code[2:0]] = 1'b0;
         end else begin
            pressed_d[key_code[2:0]] = 1'b1;
            if (!key_code[2]) pending_d[key_code[1:0]] = 1'b1;
            else              apend_d = owner_e'(key_code[2:0] - 3'd3);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         upd_q        <= 1'b1;
         frame_tick_q <= 1'b0;
         pressed_q    <= '0;
         pending_q    <= '0;
         lout_q       <= '0;
         cnt_q        <= '0;
         acnt_q       <= '0;
         owner_q      <= OWN_NONE;
         apend_q      <= OWN_NONE;
      end else begin
         upd_q        <= upd;
         frame_tick_q <= frame_tick_d;
         pressed_q    <= pressed_d;
         pending_q    <= pending_d;
         lout_q       <= lout_d;
         cnt_q        <= cnt_d;
         acnt_q       <= acnt_d;
         owner_q      <= owner_d;
         apend_q      <= apend_d;
      end
   end

   assign {dI, cI, bI, aI} = lout_q;
   assign upI        = (owner_q == OWN_UP);
   assign downI      = (owner_q == OWN_DOWN);
   assign leftI      = (owner_q == OWN_LEFT);
   assign rightI     = (owner_q == OWN_RIGHT);
   assign frame_tick = frame_tick_q;

endmodule

// File: doc/img_highlight_ctrl.md
Name: img_highlight_ctrl

Overview:
Frame-synchronous controller that drives the highlight inputs (aI, bI, cI, dI, upI, downI, leftI, rightI) of the VGA image overlay.
- Takes key make/break events from the keyboard decoder.
- Stretches each highlight over a programmable number of frames, so a tap stays visible.
- Arbitrates the four arrows so at most one arrow highlight is shown.
- Updates outputs only at a fixed raster position, so a frame is never torn mid-image.

Parameters:
HOLD_FRAMES, 8, frames a highlight persists after the last active frame tick; legal range 1..2^CNT_W-1
CNT_W, 4, hold counter width
UPDATE_LINE, 480, pixel_y at which highlights update (first blanking line)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
key_valid  in  1  one-cycle pulse: key_code/key_release valid
key_code  in  4  0=a 1=b 2=c 3=d 4=up 5=down 6=left 7=right; 8..15 ignored
key_release  in  1  1=break event, 0=make event
pixel_x  in  10  current raster x (held several clk cycles per pixel)
pixel_y  in  10  current raster y
aI, bI, cI, dI  out  1 each  letter highlight levels
upI, downI, leftI, rightI  out  1 each  arrow highlight levels, one-hot or zero
frame_tick  out  1  one-cycle pulse, high in the first cycle new highlight values are visible

Behaviour:
- Reset (reset=0, async):
  - All outputs 0.
  - All counters 0, pressed/pending flags 0, arrow owner = NONE.
  - upd_d = 1, so no spurious tick when reset releases at the update position.
- Tick generation:
  - upd = (pixel_y==UPDATE_LINE) && (pixel_x==0).
  - upd_d is registered upd.
  - tick = upd & ~upd_d (internal, combinational).
  - Exactly one tick per frame.
- Event capture (any cycle, key_valid=1, key_code<8):
  - Make sets pressed[k] and pending[k].
  - Break clears pressed[k]; pending[k] is untouched.
  - Break with no prior make: no effect beyond pressed[k]=0.
- Letter key k (0..3), on tick edge:
  - If pressed[k] | pending[k]: cnt[k] <= HOLD_FRAMES, out[k] <= 1.
  - Else if cnt[k] != 0: cnt[k] <= cnt[k]-1, out[k] <= (cnt[k]-1 != 0).
  - Else out[k] <= 0.
  - Net effect: after the last active tick, the output stays 1 for HOLD_FRAMES-1 further ticks and drops on the HOLD_FRAMES-th.
- Arrows: a single shared counter acnt and an owner register (NONE/UP/DOWN/LEFT/RIGHT).
  - Any arrow make loads arrow_pend with that code; the last make before a tick wins.
  - On tick:
    - If arrow_pend valid: owner <= arrow_pend, acnt <= HOLD_FRAMES.
    - Else if pressed[owner]: acnt <= HOLD_FRAMES.
    - Else if acnt != 0: decrement; owner <= NONE when the result is 0.
  - Arrow outputs are the one-hot decode of owner.
  - Break of a non-owner arrow only clears its pressed flag.
- Pending flags and arrow_pend clear on tick.
  - A key_valid in the same cycle as tick is recorded as new pending; set beats clear.
  - That event therefore affects the next frame, not the current one.
- Latency: outputs and frame_tick change on the clk edge at which tick=1. Between ticks, outputs are constant regardless of key traffic.
- Counter saturation: none needed; the load value is always ≤ 2^CNT_W-1.
- Reset mid-frame: state clears immediately; the next tick behaves as if no keys were pressed.

Test Plan:
- Reset with pixel_y=480, pixel_x=0 held, release reset -> no frame_tick, all outputs 0; advance to next frame -> exactly one frame_tick.
- HOLD_FRAMES=3; make 'a' then break 'a' within one frame, before the tick -> aI=1 at ticks 1,2,3, aI=0 at tick 4; bI/cI/dI stay 0.
- Hold 'c' (make, no break) for 5 ticks, then break -> cI=1 through tick 5 plus 2 more ticks (HOLD_FRAMES=3), 0 at tick 8.
- Make up, then make left in the same frame -> at tick: leftI=1, upI=0; break up -> no change; break left -> leftI drops after HOLD_FRAMES ticks, owner NONE.
- key_valid (make 'd') in the exact tick cycle -> dI=0 at that tick, dI=1 at the next tick.
- key_code=9 make, and any event mid-frame -> no output change before the next tick; codes ≥8 never change any output.
